// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - multi-channel synchroniser with debounce filter, edge pulses and sticky event flags
module sync_debounce_edge #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               DEBOUNCE  = 1,
  parameter int               EDGE_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] event_sticky,
  input  logic [WIDTH-1:0] event_clr
);

  localparam int             CW       = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] edge_pulse_q, edge_pulse_d;
  logic [WIDTH-1:0] event_sticky_q, event_sticky_d;
  logic [WIDTH-1:0] sync_out;

  // Pure register chain: only wiring between synchroniser stages.
  always_comb begin
    sync_d[0] = in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // Level flips only after DEBOUNCE consecutive cycles of disagreement.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync_out[i];
          rise_d[i]  = sync_out[i];
          fall_d[i]  = ~sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    edge_pulse_d = rise_d | fall_d;
    if (EDGE_MODE == 0) begin
      edge_pulse_d = rise_d;
    end else if (EDGE_MODE == 1) begin
      edge_pulse_d = fall_d;
    end
  end

  // A visible edge_pulse overrides a clear arriving in the same cycle.
  always_comb begin
    event_sticky_d = edge_pulse_q | (event_sticky_q & ~event_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q        <= RESET_VAL;
      rise_q         <= '0;
      fall_q         <= '0;
      edge_pulse_q   <= '0;
      event_sticky_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q        <= level_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      edge_pulse_q   <= edge_pulse_d;
      event_sticky_q <= event_sticky_d;
    end
  end

  assign level        = level_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign edge_pulse   = edge_pulse_q;
  assign event_sticky = event_sticky_q;

endmodule
